// File: rtl/largest_divisible_by_n_if.sv
// Control, memory-write and result signals of largest_divisible_by_n.
// The master side drives requests and writes; the slave side returns results and state.
interface largest_divisible_by_n_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              Start;
  logic              Ack;
  logic [DATA_W-1:0] Divisor;
  logic              Wr_en;
  logic [ADDR_W-1:0] Wr_addr;
  logic [DATA_W-1:0] Wr_data;
  logic [DATA_W-1:0] Max;
  logic [ADDR_W-1:0] Max_idx;
  logic              Qi;
  logic              Ql;
  logic              Qdiv;
  logic              Qdf;
  logic              Qdnf;

  modport master (
    output Start, Ack, Divisor, Wr_en, Wr_addr, Wr_data,
    input  Max, Max_idx, Qi, Ql, Qdiv, Qdf, Qdnf
  );

  modport slave (
    input  Start, Ack, Divisor, Wr_en, Wr_addr, Wr_data,
    output Max, Max_idx, Qi, Ql, Qdiv, Qdf, Qdnf
  );
endinterface

// File: rtl/largest_divisible_by_n.sv
// Scans a small internal memory for the largest nonzero word divisible by a runtime
// divisor, testing divisibility by repeated subtraction one step per cycle.
module largest_divisible_by_n #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  largest_divisible_by_n_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    INI       = 3'd0,
    LOAD_X    = 3'd1,
    DIV_N_UPD = 3'd2,
    DONE_F    = 3'd3,
    DONE_NF   = 3'd4
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] max_reg;
  logic [ADDR_W-1:0] max_idx_reg;
  logic [ADDR_W-1:0] i_reg;
  logic              found_reg;

  logic [DATA_W-1:0] mem_rd;
  logic              last_idx;
  logic              div_hit;

  // Combinational read: each entry gets exactly one compare cycle in LOAD_X.
  assign mem_rd   = mem[i_reg];
  assign last_idx = (i_reg == ADDR_W'(DEPTH - 1));
  assign div_hit  = (x_reg == '0);

  // Memory is only writable while idle; contents survive reset.
  always_ff @(posedge Clk) begin
    if (!Reset && state_reg == INI && bus.Wr_en)
      mem[bus.Wr_addr] <= bus.Wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= INI;
      d_reg       <= '0;
      x_reg       <= '0;
      max_reg     <= '0;
      max_idx_reg <= '0;
      i_reg       <= '0;
      found_reg   <= 1'b0;
    end else begin
      case (state_reg)
        INI: begin
          if (bus.Start) begin
            d_reg       <= bus.Divisor;
            max_reg     <= '0;
            max_idx_reg <= '0;
            i_reg       <= '0;
            found_reg   <= 1'b0;
            state_reg   <= (bus.Divisor != '0) ? LOAD_X : DONE_NF;
          end
        end
        LOAD_X: begin
          if (mem_rd > max_reg) begin
            x_reg     <= mem_rd;
            state_reg <= DIV_N_UPD;
          end else if (last_idx) begin
            state_reg <= found_reg ? DONE_F : DONE_NF;
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        DIV_N_UPD: begin
          if (x_reg >= d_reg) begin
            x_reg <= x_reg - d_reg;
          end else begin
            if (div_hit) begin
              max_reg     <= mem_rd;
              max_idx_reg <= i_reg;
              found_reg   <= 1'b1;
            end
            if (last_idx) begin
              state_reg <= (found_reg || div_hit) ? DONE_F : DONE_NF;
            end else begin
              i_reg     <= i_reg + 1'b1;
              state_reg <= LOAD_X;
            end
          end
        end
        DONE_F, DONE_NF: begin
          if (bus.Ack)
            state_reg <= INI;
        end
        default: state_reg <= INI;
      endcase
    end
  end

  assign bus.Max     = max_reg;
  assign bus.Max_idx = max_idx_reg;
  assign bus.Qi      = (state_reg == INI);
  assign bus.Ql      = (state_reg == LOAD_X);
  assign bus.Qdiv    = (state_reg == DIV_N_UPD);
  assign bus.Qdf     = (state_reg == DONE_F);
  assign bus.Qdnf    = (state_reg == DONE_NF);
endmodule

// File: doc/largest_divisible_by_n.md
LARGEST_DIVISIBLE_BY_N -- requirements
Module: largest_divisible_by_n

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bit width of memory words, divisor and result.
REQ-002 Parameter DEPTH, default 16, power of two ≥ 2, SHALL set the number of memory words; ADDR_W = log2(DEPTH) SHALL be derived locally.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes occur on the rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Start  input  1  SHALL request a scan; it is sampled only in INI.
REQ-006 Ack  input  1  SHALL acknowledge a result; it is sampled only in DONE_F and DONE_NF.
REQ-007 Divisor  input  DATA_W  SHALL be the runtime divisor, latched into internal register D on the accepted Start.
REQ-008 Wr_en  input  1  SHALL be the memory write strobe.
REQ-009 Wr_addr  input  ADDR_W  SHALL be the memory write address.
REQ-010 Wr_data  input  DATA_W  SHALL be the memory write data.
REQ-011 Max  output  DATA_W  SHALL be the largest nonzero divisible value found.
REQ-012 Max_idx  output  ADDR_W  SHALL be the address of Max.
REQ-013 Qi, Ql, Qdiv, Qdf, Qdnf  output  1 each  SHALL be one-hot state indicators for INI, LOAD_X, DIV_N_UPD, DONE_F and DONE_NF.

Function
REQ-014 Storage SHALL be an internal DEPTH x DATA_W register array M with no reset.
REQ-015 A write with Wr_en=1 SHALL update M[Wr_addr] at the clock edge only in INI; writes in any other state SHALL be ignored.
REQ-016 INI with Start=1 SHALL perform these actions at the same edge: latch D=Divisor; clear Max, Max_idx, index I and Found; go to LOAD_X if Divisor≠0, else go to DONE_NF.
REQ-017 A write and a Start in the same INI cycle SHALL both take effect; the scan SHALL see the new data.
REQ-018 LOAD_X, case M[I] > Max (unsigned, strict): the block SHALL load X=M[I] and go to DIV_N_UPD.
REQ-019 LOAD_X, otherwise: if I=DEPTH-1 the block SHALL go to DONE_F if Found=1, else DONE_NF; if I<DEPTH-1 it SHALL set I=I+1 and stay in LOAD_X.
REQ-020 DIV_N_UPD SHALL perform one step per cycle: if X ≥ D, then X=X-D and the block stays.
REQ-021 DIV_N_UPD, case X < D and X=0: the block SHALL set Max=M[I], Max_idx=I and Found=1.
REQ-022 DIV_N_UPD, case X < D (any X): the block SHALL advance exactly as LOAD_X does in REQ-019, using the updated Found.
REQ-023 Equal values SHALL not replace Max (strict compare), so Max_idx SHALL be the lowest address holding the maximum; zero entries SHALL never be results.
REQ-024 DONE_F/DONE_NF SHALL hold until Ack=1, then go to INI; Max and Max_idx SHALL stay stable in DONE and INI until the next accepted Start.
REQ-025 Start outside INI and Ack outside DONE states SHALL be ignored.
REQ-026 Latency SHALL be 1 + DEPTH (LOAD_X cycles) + Σ(floor(M[I]/D)+1) over entries entering DIV_N_UPD, counted from the Start edge to DONE entry.
REQ-027 Divisor=1 SHALL find the overall maximum nonzero entry; D > every entry SHALL yield DONE_NF.

Reset
REQ-028 Reset=1 at any edge, including mid-scan, SHALL force INI with Max=0, Max_idx=0, I=0, Found=0 and X=0.
REQ-029 Reset SHALL not alter M and SHALL take priority over Start, Ack and Wr_en.
REQ-030 The outputs SHALL be Qi=1 and all other Q signals 0 from the first edge with Reset asserted.

Verification
REQ-031 Scenario: M[15..0]=12,84,93,04,93,02,85,0E,34,23,83,90,04,46,97,34 (hex), Divisor=7 -> DONE_F, Max=93h, Max_idx=11.
REQ-032 Scenario: M[15..0]=00,01,39,53,00,68,73,91,61,39,29,59,60,39,56,73, Divisor=7 -> DONE_NF, Max=0; with M[15]=85h instead -> DONE_F, Max=85h, Max_idx=15.
REQ-033 Scenario: M[15..0]=86,85,00,...,00,73, Divisor=5 -> DONE_F, Max=73h, Max_idx=0; same data with Divisor=1 -> Max=86h, Max_idx=15.
REQ-034 Scenario: Divisor=0 with Start -> DONE_NF one cycle later, no LOAD_X visited; Ack -> INI.
REQ-035 Scenario: Reset asserted for one cycle while in DIV_N_UPD -> INI, Max=0; memory unchanged; a re-run gives the same result as an uninterrupted run.
REQ-036 Scenario: Wr_en pulsed in LOAD_X -> M unchanged; Start held through DONE -> no restart until Ack; cycle count matches REQ-026.
